// File: rtl/axil_sched_pkg.sv
// Shared types and constants for the AXI-Lite write scheduler.
// Imported by the scheduler top and by its bench.
package axil_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned CNT_W       = 16;

endpackage

// File: rtl/axil_wr_sched_if.sv
// Command and write-response taps between the scheduler and the AXI-Lite write master.
interface axil_wr_sched_if;

    logic        o_wr;
    logic [31:0] o_addrin;
    logic [31:0] o_din;
    logic [3:0]  o_strb;
    logic        i_bvalid;
    logic        i_bready;
    logic [1:0]  i_bresp;

    modport master (
        output o_wr,
        output o_addrin,
        output o_din,
        output o_strb,
        input  i_bvalid,
        input  i_bready,
        input  i_bresp
    );

    modport slave (
        input  o_wr,
        input  o_addrin,
        input  o_din,
        input  o_strb,
        output i_bvalid,
        output i_bready,
        output i_bresp
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin arbiter: first set request at or after the pointer wins.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] k;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        sum   = '0;
        k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // One extra bit keeps ptr+i from wrapping before the modulo-N fold.
            sum = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            k = sum[IDX_W-1:0];
            if (!found && i_req[k]) begin
                found    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = k;
            end
        end
    end

endmodule

// File: rtl/axil_wr_sched.sv
// Round-robin scheduler feeding single write commands from N_REQ requesters to an
// AXI-Lite write master, watching its B channel for completion or timeout.
module axil_wr_sched
    import axil_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ*32-1:0] i_req_addr,
    input  logic [N_REQ*32-1:0] i_req_data,
    input  logic [N_REQ*4-1:0]  i_req_strb,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_done,
    output logic [1:0]          o_resp,
    output logic                o_timeout,
    axil_wr_sched_if.master     bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         strb_q, strb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         resp_q, resp_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   win_gnt;
    logic [IDX_W-1:0]   win_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (win_gnt),
        .o_idx (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        timeout_d    = timeout_q;
        o_gnt        = '0;
        o_done       = '0;
        o_resp       = '0;
        bus.o_wr     = 1'b0;
        bus.o_addrin = '0;
        bus.o_din    = '0;
        bus.o_strb   = '0;

        // Captured payload is visible from ISSUE through DONE.
        if (state_q != StIdle) begin
            bus.o_addrin = addr_q;
            bus.o_din    = data_q;
            bus.o_strb   = strb_q;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Grant is combinational from i_req, so mask it while reset is held.
                if (!i_reset && (|i_req)) begin
                    o_gnt   = win_gnt;
                    owner_d = win_idx;
                    ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    addr_d  = i_req_addr[32*win_idx +: 32];
                    data_d  = i_req_data[32*win_idx +: 32];
                    strb_d  = i_req_strb[4*win_idx +: 4];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                bus.o_wr = 1'b1;
                cnt_d    = '0;
                state_d  = StWait;
            end
            StWait: begin
                if (bus.i_bvalid && bus.i_bready) begin
                    resp_d  = bus.i_bresp;
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    resp_d    = RESP_SLVERR;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                o_done[owner_q] = 1'b1;
                o_resp          = resp_q;
                cnt_d           = '0;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_axil_wr_sched.sv
// Scoreboard bench for axil_wr_sched: stimulus queues expected grants, commands and
// completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_axil_wr_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        int         idx;
        logic [1:0] resp;
        logic       to;
        int         lat;
        wr_t        pay;
    } done_t;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_req;
    logic [N*32-1:0] i_req_addr;
    logic [N*32-1:0] i_req_data;
    logic [N*4-1:0]  i_req_strb;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_done;
    logic [1:0]      o_resp;
    logic            o_timeout;

    axil_wr_sched_if bus ();

    axil_wr_sched #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
        .i_req_strb (i_req_strb),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_resp     (o_resp),
        .o_timeout  (o_timeout),
        .bus        (bus)
    );

    always #5 i_clk = ~i_clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    exp_gnt[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];

    logic       rsp_en = 1'b1;
    int         rsp_delay = 1;
    logic [1:0] rsp_val = 2'b00;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] addr_of(int k);
        return 32'h0000_1000 + 32'(k) * 32'h10;
    endfunction

    function automatic logic [31:0] data_of(int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    function automatic logic [3:0] strb_of(int k);
        return 4'(1 << k);
    endfunction

    // Monitor: every output event must match the head of its expectation queue.
    logic  busy = 1'b0;
    int    gnt_cyc = 0;
    int    eg;
    wr_t   ew;
    done_t ed;

    always @(negedge i_clk) begin
        if (i_reset) begin
            busy = 1'b0;
        end
        if (o_gnt != '0) begin
            check("gnt_done_overlap", o_done, 0);
            check("gnt_while_busy", busy, 0);
            if (exp_gnt.size() == 0) begin
                check("gnt_unexpected", o_gnt, 0);
            end else begin
                eg = exp_gnt.pop_front();
                check("gnt_onehot", o_gnt, 64'(1 << eg));
            end
            busy    = 1'b1;
            gnt_cyc = cyc;
        end
        if (bus.o_wr) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", bus.o_wr, 0);
            end else begin
                ew = exp_wr.pop_front();
                check("wr_addr", bus.o_addrin, ew.addr);
                check("wr_data", bus.o_din, ew.data);
                check("wr_strb", bus.o_strb, ew.strb);
            end
        end
        if (o_done != '0) begin
            check("done_owner_busy", busy, 1);
            if (exp_done.size() == 0) begin
                check("done_unexpected", o_done, 0);
            end else begin
                ed = exp_done.pop_front();
                check("done_onehot", o_done, 64'(1 << ed.idx));
                check("done_resp", o_resp, ed.resp);
                check("done_timeout", o_timeout, ed.to);
                check("done_latency", cyc - gnt_cyc, ed.lat + 2);
                check("done_addr_held", bus.o_addrin, ed.pay.addr);
                check("done_data_held", bus.o_din, ed.pay.data);
            end
            busy = 1'b0;
        end
    end

    // Write-master B-channel model: bvalid without bready first, handshake on WAIT cycle d-1.
    initial begin
        bus.i_bvalid = 1'b0;
        bus.i_bready = 1'b0;
        bus.i_bresp  = 2'b00;
        forever begin
            @(negedge i_clk);
            if (bus.o_wr && rsp_en) begin
                for (int j = 1; j <= rsp_delay; j++) begin
                    @(negedge i_clk);
                    bus.i_bvalid = 1'b1;
                    bus.i_bready = (j == rsp_delay);
                    bus.i_bresp  = rsp_val;
                end
                @(negedge i_clk);
                bus.i_bvalid = 1'b0;
                bus.i_bready = 1'b0;
                bus.i_bresp  = 2'b00;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_slice(int k, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        i_req_addr[k*32 +: 32] = a;
        i_req_data[k*32 +: 32] = d;
        i_req_strb[k*4 +: 4]   = s;
    endtask

    task automatic expect_txn(int k, logic [1:0] resp, logic to, int lat, wr_t pay);
        done_t d;
        d.idx  = k;
        d.resp = resp;
        d.to   = to;
        d.lat  = lat;
        d.pay  = pay;
        exp_gnt.push_back(k);
        exp_wr.push_back(pay);
        exp_done.push_back(d);
    endtask

    function automatic wr_t pay_of(int k);
        return '{addr: addr_of(k), data: data_of(k), strb: strb_of(k)};
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, "_gnt"}, o_gnt, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_resp"}, o_resp, 0);
        check({tag, "_timeout"}, o_timeout, 0);
        check({tag, "_wr"}, bus.o_wr, 0);
        check({tag, "_addrin"}, bus.o_addrin, 0);
        check({tag, "_din"}, bus.o_din, 0);
        check({tag, "_strb"}, bus.o_strb, 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic drain(int budget);
        int k = 0;
        while ((exp_gnt.size() + exp_wr.size() + exp_done.size()) != 0 && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check("drain_pending", exp_gnt.size() + exp_wr.size() + exp_done.size(), 0);
        exp_gnt.delete();
        exp_wr.delete();
        exp_done.delete();
        tick();
    endtask

    initial begin
        i_reset = 1'b1;
        i_req   = '1;
        for (int k = 0; k < N; k++) set_slice(k, addr_of(k), data_of(k), strb_of(k));

        // Reset state, with all requests pending
        repeat (2) begin
            @(negedge i_clk);
            check_all_zero("reset");
        end
        tick();
        i_reset = 1'b0;
        i_req   = '0;
        tick();

        // Single request; payload scrambled after grant must not leak
        set_slice(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        rsp_en = 1'b1; rsp_delay = 3; rsp_val = 2'b00;
        expect_txn(0, 2'b00, 1'b0, 3, '{addr: 32'h10, data: 32'hDEAD_BEEF, strb: 4'hF});
        i_req = 4'b0001;
        tick();
        i_req = '0;
        set_slice(0, 32'h0BAD_0BAD, 32'h1111_2222, 4'h3);
        drain(40);
        set_slice(0, addr_of(0), data_of(0), strb_of(0));

        // Fairness from p=0 with all requests held
        do_reset();
        rsp_delay = 1;
        expect_txn(0, 2'b00, 1'b0, 1, pay_of(0));
        expect_txn(1, 2'b00, 1'b0, 1, pay_of(1));
        expect_txn(2, 2'b00, 1'b0, 1, pay_of(2));
        expect_txn(3, 2'b00, 1'b0, 1, pay_of(3));
        expect_txn(0, 2'b00, 1'b0, 1, pay_of(0));
        i_req = 4'b1111;
        repeat (17) tick();
        i_req = '0;
        drain(60);

        // Pointer wrap: grant 2 moves p to 3, then 1001 gives 3 then 0
        rsp_delay = 2; rsp_val = 2'b01;
        expect_txn(2, 2'b01, 1'b0, 2, pay_of(2));
        i_req = 4'b0100;
        tick();
        i_req = '0;
        drain(40);
        expect_txn(3, 2'b01, 1'b0, 2, pay_of(3));
        expect_txn(0, 2'b01, 1'b0, 2, pay_of(0));
        i_req = 4'b1001;
        repeat (6) tick();
        i_req = '0;
        drain(40);

        // Timeout with no B response; flag stays set
        rsp_en = 1'b0;
        expect_txn(1, 2'b10, 1'b1, TO, pay_of(1));
        i_req = 4'b0010;
        tick();
        i_req = '0;
        drain(60);
        repeat (3) begin
            @(negedge i_clk);
            check("timeout_sticky", o_timeout, 1);
        end
        tick();

        // Handshake on the timeout cycle wins
        do_reset();
        check("timeout_cleared", o_timeout, 0);
        rsp_en = 1'b1; rsp_delay = TO; rsp_val = 2'b11;
        expect_txn(0, 2'b11, 1'b0, TO, pay_of(0));
        i_req = 4'b0001;
        tick();
        i_req = '0;
        drain(60);

        // Reset while waiting abandons the transaction and restarts at p=0
        rsp_en = 1'b0;
        exp_gnt.push_back(1);
        exp_wr.push_back(pay_of(1));
        i_req = 4'b0010;
        tick();
        i_req = '0;
        tick();
        tick();
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        i_reset = 1'b0;
        check("gnt_queue_consumed", exp_gnt.size() + exp_wr.size(), 0);
        rsp_en = 1'b1; rsp_delay = 2; rsp_val = 2'b00;
        expect_txn(1, 2'b00, 1'b0, 2, pay_of(1));
        i_req = 4'b0110;
        tick();
        i_req = '0;
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_wr_sched.md
AXIL_WR_SCHED -- requirements
Module: axil_wr_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 256, max cycles waiting for write response.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  N_REQ  per-requester write request, level, held until granted.
REQ-006 i_req_addr  input  N_REQ*32  per-requester address, slice k = bits [32k+31:32k].
REQ-007 i_req_data  input  N_REQ*32  per-requester write data, same slicing.
REQ-008 i_req_strb  input  N_REQ*4  per-requester byte strobes, slice k = bits [4k+3:4k].
REQ-009 o_gnt  output  N_REQ  one-hot, single-cycle pulse: request accepted, payload captured.
REQ-010 o_done  output  N_REQ  one-hot, single-cycle pulse: granted transaction finished.
REQ-011 o_resp  output  2  response for the o_done cycle; 2'b00 OKAY, from bus or timeout code.
REQ-012 o_timeout  output  1  sticky flag: some transaction exceeded TIMEOUT_CYC.
REQ-013 o_wr, o_addrin[31:0], o_din[31:0], o_strb[3:0]  outputs  command to the AXI-Lite write master.
REQ-014 i_bvalid, i_bready  input  1 each  taps of master's write response channel.
REQ-015 i_bresp  input  2  tap of master's bresp.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE: if any i_req bit set, pick winner by round-robin, capture its addr/data/strb, pulse o_gnt[winner], go ISSUE; else stay.
REQ-018 Round-robin: search starts at pointer p, increments modulo N_REQ; first set bit wins; p becomes winner+1 mod N_REQ at grant.
REQ-019 ISSUE: o_wr=1 for exactly one cycle with captured payload on o_addrin/o_din/o_strb; go WAIT.
REQ-020 o_addrin/o_din/o_strb hold captured values from ISSUE until DONE exits; zero otherwise.
REQ-021 WAIT: on i_bvalid && i_bready, latch i_bresp, go DONE.
REQ-022 WAIT: 16-bit cycle counter starts at 0 on entry; when it reaches TIMEOUT_CYC-1 without handshake, set o_resp to 2'b10 (SLVERR), set o_timeout, go DONE.
REQ-023 Handshake and timeout in same cycle: handshake wins, bus bresp reported, o_timeout unchanged.
REQ-024 DONE: pulse o_done[owner] with o_resp valid that cycle; go IDLE.
REQ-025 Minimum request-to-request spacing: grant, issue, >=1 wait, done, so 4 cycles per transaction; no grant while not IDLE.
REQ-026 Requests arriving/dropping while busy have no effect; a request dropped before grant is never served.
REQ-027 Captured payload unaffected by input changes after the o_gnt cycle.
REQ-028 o_gnt and o_done never both asserted same cycle; each at most one bit set.

Reset
REQ-029 On i_reset: state IDLE, p=0, counter 0, o_gnt=0, o_done=0, o_resp=0, o_timeout=0, o_wr=0, o_addrin=0, o_din=0, o_strb=0.
REQ-030 Reset mid-transaction abandons it: no o_done for the owner; reset takes effect immediately (asynchronous), release synchronous to i_clk by system.
REQ-031 o_timeout cleared only by reset.

Structure
REQ-032 Package axil_sched_pkg holds state enum, RESP_OKAY/RESP_SLVERR constants, counter width constant.
REQ-033 Round-robin selection in sub-module rr_pick (combinational: request vector, pointer in; one-hot winner and index out).
REQ-034 Single-cycle o_wr pulse matches master's requirement that i_wr be sampled only while its bready is low.

Verification
REQ-035 Single request: i_req=4'b0001, addr 0x10, data 0xDEADBEEF, strb 0xF; bresp 00 after 3 cycles -> o_gnt[0], o_wr one cycle with those values, o_done[0], o_resp 00.
REQ-036 Fairness: i_req=4'b1111 held -> grants in order 0,1,2,3,0; each o_done before next o_gnt.
REQ-037 Pointer wrap: p=3, i_req=4'b1001 -> grant 3 then 0.
REQ-038 Timeout: TIMEOUT_CYC=8, bvalid never asserted -> o_done after 8 WAIT cycles, o_resp 10, o_timeout 1 and stays 1.
REQ-039 Error response: bresp 2'b11 with handshake on timeout cycle -> o_resp 11, o_timeout 0.
REQ-040 Reset in WAIT: assert i_reset -> all outputs zero immediately, no o_done; next request granted with p=0.
